// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the MIPS32 multi-cycle controller and its datapath
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADDU = 3'd0;
  localparam logic [2:0] ALU_SUBU = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  typedef struct packed {
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic is_ori;
    logic is_addiu;
    logic is_lui;
    logic is_illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction-class one-hot decode
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: cls.is_rtype   = 1'b1;
          FN_JR:                                   cls.is_jr      = 1'b1;
          default:                                 cls.is_illegal = 1'b1;
        endcase
      end
      OP_J:     cls.is_j       = 1'b1;
      OP_JAL:   cls.is_jal     = 1'b1;
      OP_BEQ:   cls.is_beq     = 1'b1;
      OP_ADDIU: cls.is_addiu   = 1'b1;
      OP_ORI:   cls.is_ori     = 1'b1;
      OP_LUI:   cls.is_lui     = 1'b1;
      OP_LW:    cls.is_lw      = 1'b1;
      OP_SW:    cls.is_sw      = 1'b1;
      default:  cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS32 main controller FSM
// MC_ILLEGAL_TRAP_EN: undefined instructions latch illegal and park in TRAP instead of acting as NOP.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int S_W    = 3,
  parameter int RA_IDX = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     opcode,
  input  logic [5:0]     funct,
  input  logic           zero,
  output logic           PC_Wr,
  output logic           IR_Wr,
  output logic           RF_Wr,
  output logic           DM_Wr,
  output logic [1:0]     NPC_Op,
  output logic [2:0]     ALU_Op,
  output logic           B_Sel,
  output logic [1:0]     Ext_Op,
  output logic [1:0]     RegDst,
  output logic [1:0]     WD_Sel,
  output logic [S_W-1:0] state,
  output logic           illegal
);

  state_e       r_state;
  state_e       w_next;
  instr_class_t w_cls;
  logic         w_exec_sel;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (w_cls)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  assign state = S_W'(r_state);

  always_comb begin
    w_next     = ST_FETCH;
    PC_Wr      = 1'b0;
    IR_Wr      = 1'b0;
    RF_Wr      = 1'b0;
    DM_Wr      = 1'b0;
    NPC_Op     = NPC_PC4;
    ALU_Op     = ALU_ADDU;
    B_Sel      = 1'b0;
    Ext_Op     = EXT_ZERO;
    RegDst     = RD_RT;
    WD_Sel     = WD_ALU;
    w_exec_sel = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

    // EXEC selects stay applied through MEM and WB so the ALU result is stable.
    if (w_exec_sel) begin
      if (w_cls.is_rtype) begin
        case (funct)
          FN_SUBU: ALU_Op = ALU_SUBU;
          FN_OR:   ALU_Op = ALU_OR;
          FN_SLT:  ALU_Op = ALU_SLT;
          FN_AND:  ALU_Op = ALU_AND;
          default: ALU_Op = ALU_ADDU;
        endcase
      end else if (w_cls.is_ori) begin
        ALU_Op = ALU_OR;
        B_Sel  = 1'b1;
        Ext_Op = EXT_ZERO;
      end else if (w_cls.is_addiu || w_cls.is_lw || w_cls.is_sw) begin
        B_Sel  = 1'b1;
        Ext_Op = EXT_SIGN;
      end else if (w_cls.is_lui) begin
        B_Sel  = 1'b1;
        Ext_Op = EXT_LUI;
      end
    end

    case (r_state)
      ST_FETCH: begin
        IR_Wr  = 1'b1;
        PC_Wr  = 1'b1;
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_cls.is_j || w_cls.is_jal) begin
          PC_Wr  = 1'b1;
          NPC_Op = NPC_J;
          if (w_cls.is_jal) begin
            RF_Wr  = 1'b1;
            RegDst = RD_RA;
            WD_Sel = WD_PC4;
          end
          w_next = ST_FETCH;
        end else if (w_cls.is_jr) begin
          PC_Wr  = 1'b1;
          NPC_Op = NPC_JR;
          w_next = ST_FETCH;
        end else if (w_cls.is_beq) begin
          w_next = ST_BRANCH;
        end else if (w_cls.is_illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = ST_TRAP;
`else
          w_next = ST_FETCH;
`endif
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC:   w_next = (w_cls.is_lw || w_cls.is_sw) ? ST_MEM : ST_WB;
      ST_MEM: begin
        DM_Wr  = w_cls.is_sw;
        w_next = w_cls.is_lw ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        RF_Wr  = 1'b1;
        RegDst = w_cls.is_rtype ? RD_RD : RD_RT;
        WD_Sel = w_cls.is_lw ? WD_DM : WD_ALU;
      end
      ST_BRANCH: begin
        ALU_Op = ALU_SUBU;
        B_Sel  = 1'b0;
        NPC_Op = NPC_BR;
        PC_Wr  = zero;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:   w_next = ST_TRAP;
`endif
      default:   w_next = ST_FETCH;
    endcase

    if (rst) begin
      PC_Wr  = 1'b0;
      IR_Wr  = 1'b0;
      RF_Wr  = 1'b0;
      DM_Wr  = 1'b0;
      NPC_Op = NPC_PC4;
      ALU_Op = ALU_ADDU;
      B_Sel  = 1'b0;
      Ext_Op = EXT_ZERO;
      RegDst = RD_RT;
      WD_Sel = WD_ALU;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (rst)                                              r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && w_cls.is_illegal)    r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm with a per-instruction reference model
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       PC_Wr, IR_Wr, RF_Wr, DM_Wr, B_Sel, illegal;
  logic [1:0] NPC_Op, Ext_Op, RegDst, WD_Sel;
  logic [2:0] ALU_Op;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.S_W(3), .RA_IDX(31)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .PC_Wr(PC_Wr), .IR_Wr(IR_Wr), .RF_Wr(RF_Wr), .DM_Wr(DM_Wr),
    .NPC_Op(NPC_Op), .ALU_Op(ALU_Op), .B_Sel(B_Sel), .Ext_Op(Ext_Op),
    .RegDst(RegDst), .WD_Sel(WD_Sel), .state(state), .illegal(illegal)
  );

  typedef enum int {K_R, K_ORI, K_ADDIU, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_e;
  typedef struct {
    kind_e      k;
    logic [5:0] op;
    logic [5:0] fn;
  } ent_t;
  ent_t tbl[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int path_len(input kind_e k);
    case (k)
      K_J, K_JAL, K_JR, K_ILL: return 2;
      K_BEQ:                   return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  // State visited in cycle n of an instruction: FETCH, DECODE, then EXEC/BRANCH, MEM/WB, WB.
  function automatic int path_state(input kind_e k, input int n);
    if (n == 0) return 0;
    if (n == 1) return 1;
    if (n == 2) return (k == K_BEQ) ? 5 : 2;
    if (n == 3) return (k == K_LW || k == K_SW) ? 3 : 4;
    return 4;
  endfunction

  function automatic int alu_code(input kind_e k, input logic [5:0] fn);
    if (k == K_ORI) return 2;
    if (k != K_R) return 0;
    case (fn)
      6'h23:   return 1;
      6'h25:   return 2;
      6'h2A:   return 3;
      6'h24:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit writes_reg_in_wb(input kind_e k);
    return k == K_R || k == K_ORI || k == K_ADDIU || k == K_LUI || k == K_LW;
  endfunction

  task automatic run_instr(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input string nm);
    int  len;
    bit  e_pc, e_rf, e_dm;
    opcode = op;
    funct  = fn;
    zero   = z;
    len    = path_len(k);
    for (int n = 0; n < len; n++) begin
      #1;
      e_pc = (n == 0) || (n == 1 && (k == K_J || k == K_JAL || k == K_JR)) || (k == K_BEQ && n == 2 && z);
      e_rf = (k == K_JAL && n == 1) || (n == len - 1 && writes_reg_in_wb(k));
      e_dm = (k == K_SW && n == 3);
      chk({nm, ".state"}, 32'(state), 32'(path_state(k, n)));
      chk({nm, ".PC_Wr"}, 32'(PC_Wr), 32'(e_pc));
      chk({nm, ".IR_Wr"}, 32'(IR_Wr), 32'(n == 0));
      chk({nm, ".RF_Wr"}, 32'(RF_Wr), 32'(e_rf));
      chk({nm, ".DM_Wr"}, 32'(DM_Wr), 32'(e_dm));
      if (n == 0) chk({nm, ".NPC_fetch"}, 32'(NPC_Op), 32'd0);
      if (n == 1 && (k == K_J || k == K_JAL)) chk({nm, ".NPC_j"}, 32'(NPC_Op), 32'd2);
      if (n == 1 && k == K_JR) chk({nm, ".NPC_jr"}, 32'(NPC_Op), 32'd3);
      if (n == 2 && k == K_BEQ) begin
        chk({nm, ".NPC_br"}, 32'(NPC_Op), 32'd1);
        chk({nm, ".ALU_br"}, 32'(ALU_Op), 32'd1);
        chk({nm, ".BSel_br"}, 32'(B_Sel), 32'd0);
      end
      if (n == 2 && k != K_BEQ) begin
        chk({nm, ".ALU_exec"}, 32'(ALU_Op), 32'(alu_code(k, fn)));
        if (k == K_R) chk({nm, ".BSel_exec"}, 32'(B_Sel), 32'd0);
        if (k == K_ORI || k == K_LW || k == K_SW) chk({nm, ".BSel_exec"}, 32'(B_Sel), 32'd1);
        if (k == K_ORI) chk({nm, ".Ext_exec"}, 32'(Ext_Op), 32'd0);
        if (k == K_ADDIU || k == K_LW || k == K_SW) chk({nm, ".Ext_exec"}, 32'(Ext_Op), 32'd1);
        if (k == K_LUI) chk({nm, ".Ext_exec"}, 32'(Ext_Op), 32'd2);
      end
      if (e_rf) begin
        chk({nm, ".RegDst"}, 32'(RegDst), (k == K_JAL) ? 32'd2 : (k == K_R) ? 32'd1 : 32'd0);
        chk({nm, ".WD_Sel"}, 32'(WD_Sel), (k == K_JAL) ? 32'd2 : (k == K_LW) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, ".enables"}, 32'({PC_Wr, IR_Wr, RF_Wr, DM_Wr}), 32'd0);
  endtask

  initial begin
    ent_t e;
    tbl.push_back('{K_R,     6'h00, 6'h21});
    tbl.push_back('{K_R,     6'h00, 6'h23});
    tbl.push_back('{K_R,     6'h00, 6'h2A});
    tbl.push_back('{K_R,     6'h00, 6'h24});
    tbl.push_back('{K_R,     6'h00, 6'h25});
    tbl.push_back('{K_JR,    6'h00, 6'h08});
    tbl.push_back('{K_ORI,   6'h0D, 6'h00});
    tbl.push_back('{K_ADDIU, 6'h09, 6'h00});
    tbl.push_back('{K_LUI,   6'h0F, 6'h00});
    tbl.push_back('{K_LW,    6'h23, 6'h00});
    tbl.push_back('{K_SW,    6'h2B, 6'h00});
    tbl.push_back('{K_BEQ,   6'h04, 6'h00});
    tbl.push_back('{K_J,     6'h02, 6'h00});
    tbl.push_back('{K_JAL,   6'h03, 6'h00});
`ifndef MC_ILLEGAL_TRAP_EN
    tbl.push_back('{K_ILL,   6'h3F, 6'h00});
    tbl.push_back('{K_ILL,   6'h00, 6'h00});
`endif

    rst = 1'b1;
    @(negedge clk);
    #1 check_quiet("rst_c1");
    chk("rst_c1.state", 32'(state), 32'd0);
    @(negedge clk);
    #1 check_quiet("rst_c2");
    chk("rst_c2.sel", 32'({NPC_Op, ALU_Op, B_Sel, Ext_Op, RegDst, WD_Sel}), 32'd0);
    chk("rst_c2.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(K_R,   6'h00, 6'h21, 1'b0, "addu");
    run_instr(K_LW,  6'h23, 6'h00, 1'b0, "lw");
    run_instr(K_SW,  6'h2B, 6'h00, 1'b0, "sw");
    run_instr(K_BEQ, 6'h04, 6'h00, 1'b1, "beq_taken");
    run_instr(K_BEQ, 6'h04, 6'h00, 1'b0, "beq_not");
    run_instr(K_JAL, 6'h03, 6'h00, 1'b0, "jal");
    run_instr(K_ORI, 6'h0D, 6'h15, 1'b1, "ori");

    for (int i = 0; i < 150; i++) begin
      e = tbl[$urandom_range(tbl.size() - 1)];
      if (e.op != 6'h00) e.fn = 6'($urandom);
      run_instr(e.k, e.op, e.fn, 1'($urandom), $sformatf("rnd%0d", i));
    end
    chk("rnd.illegal", 32'(illegal), 32'd0);

    opcode = 6'h23;
    funct  = 6'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_quiet("midrst");
    @(negedge clk);
    chk("midrst.state", 32'(state), 32'd0);
    rst = 1'b0;
    run_instr(K_SW, 6'h2B, 6'h00, 1'b0, "after_midrst");

`ifdef MC_ILLEGAL_TRAP_EN
    opcode = 6'h3F;
    #1 chk("trap.fetch", 32'(IR_Wr), 32'd1);
    @(negedge clk);
    #1 chk("trap.decode_state", 32'(state), 32'd1);
    check_quiet("trap.decode");
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      #1 chk("trap.state", 32'(state), 32'd6);
      chk("trap.illegal", 32'(illegal), 32'd1);
      check_quiet("trap.hold");
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1 chk("trap.rst_illegal", 32'(illegal), 32'd0);
    chk("trap.rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    run_instr(K_R, 6'h00, 6'h25, 1'b0, "after_trap");
`else
    run_instr(K_ILL, 6'h3F, 6'h00, 1'b0, "undef_op");
    #1 chk("undef.state", 32'(state), 32'd0);
    chk("undef.illegal", 32'(illegal), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle main controller for the MIPS32 core.
- Sits directly downstream of the instruction register: it consumes the latched opcode/funct fields and the ALU zero flag.
- It generates every write enable and mux select for the datapath, including IR_Wr back to the instruction register.
- Sequencing is one state per clock; instruction latency ranges from 2 to 5 cycles.

Parameters:
- S_W, 3, state register width.
- RA_IDX, 31, register index written by jal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU result==0, valid in BRANCH state.
- PC_Wr  out  1  PC write enable.
- IR_Wr  out  1  instruction register write enable.
- RF_Wr  out  1  register file write enable.
- DM_Wr  out  1  data memory write enable.
- NPC_Op  out  2  00 PC+4, 01 branch target, 10 {PC[31:28],idx26,2'b00}, 11 rs (jr).
- ALU_Op  out  3  0 ADDU, 1 SUBU, 2 OR, 3 SLT, 4 AND.
- B_Sel  out  1  0 rt, 1 extended imm.
- Ext_Op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16.
- RegDst  out  2  0 rt, 1 rd, 2 RA_IDX.
- WD_Sel  out  2  0 ALU result, 1 DM read data, 2 PC+4.
- state  out  S_W  current state, for debug/verification.
- illegal  out  1  sticky illegal-instruction flag; present only with MC_ILLEGAL_TRAP_EN, otherwise tied 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; at the clk edge with rst=1, state<=FETCH and illegal<=0. While rst=1, all write enables (PC_Wr, IR_Wr, RF_Wr, DM_Wr) are forced 0 and selects are 0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, TRAP=6.
- Outputs are combinational from state, opcode and funct (Moore plus decode). opcode/funct are valid from DECODE onward, because the instruction register captures at the end of FETCH.
- FETCH: IR_Wr=1, PC_Wr=1, NPC_Op=00. Next state DECODE.
- DECODE, by instruction:
  - j: PC_Wr=1, NPC_Op=10; next FETCH.
  - jal: additionally RF_Wr=1, RegDst=2, WD_Sel=2; next FETCH.
  - jr (op 000000, funct 001000): PC_Wr=1, NPC_Op=11; next FETCH.
  - beq (000100): next BRANCH.
  - All other legal instructions: next EXEC.
- EXEC, by instruction:
  - R-type (addu 100001, subu 100011, slt 101010, and 100100, or 100101): B_Sel=0, ALU_Op from funct.
  - ori (001101): B_Sel=1, Ext_Op=0, ALU_Op=OR.
  - addiu (001001): Ext_Op=1, ALU_Op=ADDU.
  - lui (001111): Ext_Op=2, ALU_Op=ADDU with A forced via rs=$0 by the compiler convention; the block only drives selects.
  - lw (100011) / sw (101011): Ext_Op=1, B_Sel=1, ALU_Op=ADDU; next MEM.
  - All other EXEC cases: next WB.
- MEM: hold EXEC selects.
  - sw: DM_Wr=1; next FETCH.
  - lw: no write; next WB.
- WB: RF_Wr=1. RegDst=1 for R-type, else 0. WD_Sel=1 for lw, else 0. Next FETCH.
- BRANCH: ALU_Op=SUBU, B_Sel=0, NPC_Op=01, PC_Wr=zero. Next FETCH.
- Latencies: j/jal/jr 2 cycles; beq 3; R/I-ALU/sw 4; lw 5.
- Undefined opcode or funct in DECODE (feature off): treated as NOP, next FETCH, no writes.
- Mid-operation reset: the state is abandoned and no partial write is issued in the reset cycle.
- At most one of RF_Wr/DM_Wr is high in any cycle. IR_Wr is high only in FETCH.

Optional Feature:
- MC_ILLEGAL_TRAP_EN defined: an undefined opcode/funct in DECODE sets illegal<=1 and the next state is TRAP. TRAP holds forever with all enables 0; only rst exits it.
- Not defined: illegal is tied 0, the TRAP state is unreachable, and undefined instructions behave as a 2-cycle NOP.

Decomposition:
- Package mc_pkg holds:
  - state encodings;
  - opcode/funct localparams;
  - ALU_Op, NPC_Op, Ext_Op, RegDst and WD_Sel encodings, shared with the ALU, NPC, EXT and mux modules.
- One sub-module, mc_decode: purely combinational opcode/funct to instruction-class one-hots (is_rtype, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_ori, is_addiu, is_lui, is_illegal).
- The FSM and output logic stay in mc_ctrl_fsm.

Test Plan:
- rst=1 for 2 cycles, then release -> state=0, IR_Wr=1, PC_Wr=1 on the first cycle; all enables 0 during rst.
- addu (op 0, funct 0x21) -> states 0,1,2,4. In EXEC ALU_Op=0, B_Sel=0. In WB RF_Wr=1, RegDst=1, WD_Sel=0.
- lw (0x23) then sw (0x2B):
  - lw: states 0,1,2,3,4; WB has WD_Sel=1, RegDst=0.
  - sw: states 0,1,2,3; DM_Wr=1 in MEM only; RF_Wr never 1.
- beq (0x04) with zero=1, then again with zero=0 -> BRANCH reached in cycle 3 both times. zero=1 gives PC_Wr=1, NPC_Op=01; zero=0 gives PC_Wr=0.
- jal (0x03) -> DECODE has PC_Wr=1, NPC_Op=10, RF_Wr=1, RegDst=2, WD_Sel=2; back to FETCH after 2 cycles.
- opcode 0x3F:
  - MC_ILLEGAL_TRAP_EN defined: illegal=1, state=6 held for 10 cycles with no enables; rst recovers to FETCH.
  - Not defined: FETCH follows DECODE, no writes.
